// File: rtl/lenet5_sched_pkg.sv
// Shared types and helpers for the LeNet-5 frame admission scheduler.
package lenet5_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DROP   = 2'd2
    } sched_state_t;

    localparam int DEF_PIX_PER_FRAME = 1024;

    // Occupancy counters must be able to represent a completely full FIFO.
    function automatic int occ_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lenet5_tag_fifo.sv
// In-order tag FIFO with a first-word-fall-through head. The caller never
// pushes when full or pops when empty.
module lenet5_tag_fifo
    import lenet5_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = occ_bits(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/lenet5_frame_sched.sv
// Frame admission controller for the LeNet-5 core with in-order tag tracking.
// Optional watchdog enabled by defining LENET_SCHED_WDOG_EN.
module lenet5_frame_sched
    import lenet5_sched_pkg::*;
#(
    parameter int PIX_BITS      = 8,
    parameter int PIX_PER_FRAME = DEF_PIX_PER_FRAME,
    parameter int MAX_INFLIGHT  = 2,
    parameter int CNT_BITS      = 16,
`ifdef LENET_SCHED_WDOG_EN
    parameter int WDOG_CYCLES   = 200000,
`endif
    localparam int OCC_W        = occ_bits(MAX_INFLIGHT),
    localparam int PC_W         = $clog2(PIX_PER_FRAME)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                weights_loaded,
    input  logic                fr_start,
    input  logic                fr_v,
    input  logic [PIX_BITS-1:0] fr_pix,
    input  logic [3:0]          fr_num,
    output logic                core_in_valid,
    output logic [PIX_BITS-1:0] core_in_pix,
    input  logic                core_pred_valid,
    input  logic [3:0]          core_pred_digit,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [3:0]          res_num,
    output logic [3:0]          res_digit,
    output logic [OCC_W-1:0]    inflight,
    output logic [CNT_BITS-1:0] acc_cnt,
    output logic [CNT_BITS-1:0] drop_cnt,
    output logic                err
);

    sched_state_t  state_reg;
    logic [PC_W-1:0] pix_cnt_reg;
    logic [3:0]    head_tag;
    logic          wdog_fire;
    logic          admit;
    logic          fwd;
    logic          last_pix;
    logic          fifo_empty;
    logic          pop;
    logic [PC_W-1:0] cnt_cur;

    assign fifo_empty = (inflight == '0);
    assign pop        = core_pred_valid && !fifo_empty;

    // Admission looks only at registered occupancy; a same-cycle pop does not free a slot.
    assign admit = fr_start && (state_reg != ST_STREAM) && !wdog_fire && weights_loaded
                   && (inflight < OCC_W'(MAX_INFLIGHT)) && !(res_valid && !res_ready);
    assign fwd      = fr_v && ((state_reg == ST_STREAM) || admit);
    assign cnt_cur  = (state_reg == ST_STREAM) ? pix_cnt_reg : '0;
    assign last_pix = (cnt_cur == PC_W'(PIX_PER_FRAME - 1));

    lenet5_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .W     (4)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (admit),
        .pop   (pop),
        .flush (wdog_fire),
        .din   (fr_num),
        .dout  (head_tag),
        .count (inflight)
    );

`ifdef LENET_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_cnt_reg;

    assign wdog_fire = !fifo_empty && !core_pred_valid
                       && (wdog_cnt_reg == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_reg <= '0;
        end else if (fifo_empty || core_pred_valid || wdog_fire) begin
            wdog_cnt_reg <= '0;
        end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pix_cnt_reg   <= '0;
            core_in_valid <= 1'b0;
            core_in_pix   <= '0;
            res_valid     <= 1'b0;
            res_num       <= '0;
            res_digit     <= '0;
            acc_cnt       <= '0;
            drop_cnt      <= '0;
            err           <= 1'b0;
        end else begin
            core_in_valid <= 1'b0;
            if (fwd) begin
                core_in_valid <= 1'b1;
                core_in_pix   <= fr_pix;
                pix_cnt_reg   <= last_pix ? '0 : cnt_cur + 1'b1;
            end else if (admit) begin
                pix_cnt_reg   <= '0;
            end

            if (wdog_fire) begin
                state_reg <= ST_IDLE;
            end else if (admit) begin
                state_reg <= (fwd && last_pix) ? ST_IDLE : ST_STREAM;
            end else if (fr_start && state_reg != ST_STREAM) begin
                state_reg <= ST_DROP;
            end else if (state_reg == ST_STREAM && fwd && last_pix) begin
                state_reg <= ST_IDLE;
            end

            if (admit && acc_cnt != '1) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (fr_start && !admit && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end

            // A fresh prediction wins over the accept, so the result reloads back-to-back.
            if (pop) begin
                res_valid <= 1'b1;
                res_num   <= head_tag;
                res_digit <= core_pred_digit;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            if ((fr_start && state_reg == ST_STREAM) || (core_pred_valid && fifo_empty)
                || (pop && res_valid && !res_ready) || wdog_fire) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lenet5_frame_sched.sv
// Directed bench for lenet5_frame_sched: admission, drop, tag ordering and result handshake.
module tb_lenet5_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        weights_loaded;
    logic        fr_start;
    logic        fr_v;
    logic [7:0]  fr_pix;
    logic [3:0]  fr_num;
    logic        core_in_valid;
    logic [7:0]  core_in_pix;
    logic        core_pred_valid;
    logic [3:0]  core_pred_digit;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_num;
    logic [3:0]  res_digit;
    logic [1:0]  inflight;
    logic [15:0] acc_cnt;
    logic [15:0] drop_cnt;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    int pix_bad = 0;
    int cur_num = 0;

`ifdef LENET_SCHED_WDOG_EN
    lenet5_frame_sched #(.WDOG_CYCLES(100)) dut (
`else
    lenet5_frame_sched dut (
`endif
        .clk             (clk),
        .rst_n           (rst_n),
        .weights_loaded  (weights_loaded),
        .fr_start        (fr_start),
        .fr_v            (fr_v),
        .fr_pix          (fr_pix),
        .fr_num          (fr_num),
        .core_in_valid   (core_in_valid),
        .core_in_pix     (core_in_pix),
        .core_pred_valid (core_pred_valid),
        .core_pred_digit (core_pred_digit),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_num         (res_num),
        .res_digit       (res_digit),
        .inflight        (inflight),
        .acc_cnt         (acc_cnt),
        .drop_cnt        (drop_cnt),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Count forwarded pixels and check each against the pattern the bench drives.
    always @(negedge clk) begin
        if (core_in_valid) begin
            if (core_in_pix !== 8'(pulse_cnt * 3 + cur_num)) pix_bad++;
            pulse_cnt++;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; a second fr_start (id 8) is injected at pixel intr_at when intr_at >= 0.
    task automatic send_frame(input int num, input int npix, input int intr_at, input bit chk_lat);
        cur_num   = num;
        pulse_cnt = 0;
        pix_bad   = 0;
        for (int i = 0; i < npix; i++) begin
            fr_start = (i == 0) || (i == intr_at);
            fr_num   = (i == 0) ? 4'(num) : 4'd8;
            fr_v     = 1'b1;
            fr_pix   = 8'(i * 3 + num);
            tick();
            if (chk_lat && i == 0) begin
                check_val("lat_valid", int'(core_in_valid), 1);
                check_val("lat_pix", int'(core_in_pix), num);
            end
        end
        fr_start = 1'b0;
        fr_v     = 1'b0;
        tick();
        tick();
    endtask

    task automatic pred(input int digit);
        core_pred_valid = 1'b1;
        core_pred_digit = 4'(digit);
        tick();
        core_pred_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        weights_loaded = 1'b1;
        fr_start = 1'b0;
        fr_v = 1'b0;
        fr_pix = '0;
        fr_num = '0;
        core_pred_valid = 1'b0;
        core_pred_digit = '0;
        res_ready = 1'b1;
        tick();
        tick();
        check_val("rst_res_valid", int'(res_valid), 0);
        check_val("rst_core_valid", int'(core_in_valid), 0);
        check_val("rst_inflight", int'(inflight), 0);
        check_val("rst_acc", int'(acc_cnt), 0);
        check_val("rst_drop", int'(drop_cnt), 0);
        check_val("rst_err", int'(err), 0);
        rst_n = 1'b1;
        tick();

        // Single admitted frame then its prediction.
        send_frame(5, 1024, -1, 1'b1);
        check_val("f5_pulses", pulse_cnt, 1024);
        check_val("f5_pixdata_bad", pix_bad, 0);
        check_val("f5_acc", int'(acc_cnt), 1);
        check_val("f5_inflight", int'(inflight), 1);
        pred(7);
        check_val("f5_res_valid", int'(res_valid), 1);
        check_val("f5_res_num", int'(res_num), 5);
        check_val("f5_res_digit", int'(res_digit), 7);
        check_val("f5_inflight_after", int'(inflight), 0);
        tick();
        check_val("f5_res_taken", int'(res_valid), 0);

        // Weights not loaded: frame dropped, stays in DROP until next fr_start.
        weights_loaded = 1'b0;
        send_frame(3, 20, -1, 1'b0);
        check_val("nw_pulses", pulse_cnt, 0);
        check_val("nw_drop", int'(drop_cnt), 1);
        weights_loaded = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            fr_v = 1'b1;
            tick();
        end
        fr_v = 1'b0;
        tick();
        check_val("drop_hold_pulses", pulse_cnt, 0);

        // Budget of two in flight, third frame dropped, tags return in order.
        send_frame(1, 1024, -1, 1'b0);
        check_val("f1_pulses", pulse_cnt, 1024);
        send_frame(2, 1024, -1, 1'b0);
        check_val("f2_pulses", pulse_cnt, 1024);
        check_val("f2_acc", int'(acc_cnt), 3);
        send_frame(3, 20, -1, 1'b0);
        check_val("f3_pulses", pulse_cnt, 0);
        check_val("f3_drop", int'(drop_cnt), 2);
        check_val("f3_inflight", int'(inflight), 2);
        pred(4);
        check_val("ord1_num", int'(res_num), 1);
        check_val("ord1_digit", int'(res_digit), 4);
        tick();
        pred(9);
        check_val("ord2_num", int'(res_num), 2);
        check_val("ord2_digit", int'(res_digit), 9);
        check_val("ord_inflight", int'(inflight), 0);
        tick();

        // fr_start mid-stream: dropped with error, current frame completes.
        check_val("pre_intr_err", int'(err), 0);
        send_frame(6, 1024, 500, 1'b0);
        check_val("intr_pulses", pulse_cnt, 1024);
        check_val("intr_pixdata_bad", pix_bad, 0);
        check_val("intr_drop", int'(drop_cnt), 3);
        check_val("intr_err", int'(err), 1);
        check_val("intr_inflight", int'(inflight), 1);
        pred(2);
        check_val("intr_res_num", int'(res_num), 6);
        tick();

        // Result held by consumer blocks admission; accept plus new prediction reloads.
        send_frame(10, 1024, -1, 1'b0);
        send_frame(12, 1024, -1, 1'b0);
        check_val("hs_acc", int'(acc_cnt), 6);
        res_ready = 1'b0;
        pred(3);
        tick();
        tick();
        check_val("hs_hold_valid", int'(res_valid), 1);
        send_frame(11, 20, -1, 1'b0);
        check_val("hs_blk_pulses", pulse_cnt, 0);
        check_val("hs_blk_drop", int'(drop_cnt), 4);
        check_val("hs_stable_num", int'(res_num), 10);
        check_val("hs_stable_digit", int'(res_digit), 3);
        res_ready = 1'b1;
        pred(8);
        check_val("hs_reload_valid", int'(res_valid), 1);
        check_val("hs_reload_num", int'(res_num), 12);
        check_val("hs_reload_digit", int'(res_digit), 8);
        check_val("hs_inflight", int'(inflight), 0);
        tick();
        check_val("hs_final_valid", int'(res_valid), 0);

`ifdef LENET_SCHED_WDOG_EN
        fr_start = 1'b1;
        fr_num = 4'd4;
        tick();
        fr_start = 1'b0;
        check_val("wd_inflight_pre", int'(inflight), 1);
        for (int i = 0; i < 105; i++) tick();
        check_val("wd_inflight", int'(inflight), 0);
        check_val("wd_err", int'(err), 1);
        send_frame(7, 1024, -1, 1'b0);
        check_val("wd_next_pulses", pulse_cnt, 1024);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lenet5_frame_sched.md
Name: lenet5_frame_sched

Overview:
- Frame-level admission controller between the preprocess pixel stream and the LeNet-5 core.
- Decides per frame whether to admit it to the core or drop it. Admission requires all of: weights loaded, in-flight budget available, result path free.
- Tags each admitted frame's image number in an in-order tag FIFO. Pairs tags with core predictions and presents {image_num, digit} on a valid/ready result port.
- Replaces fixed frame-delay alignment with explicit tag tracking.

Parameters:
- PIX_BITS, 8, pixel width.
- PIX_PER_FRAME, 1024, valid pixels per frame (32x32).
- MAX_INFLIGHT, 2, admitted frames awaiting prediction; equals tag FIFO depth; power of 2, >=2.
- CNT_BITS, 16, width of statistics counters.
- WDOG_CYCLES, 200000, watchdog limit; used only with the optional feature.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- weights_loaded, in, 1, weight ROM load complete (level).
- fr_start, in, 1, 1-cycle pulse at frame start.
- fr_v, in, 1, pixel valid.
- fr_pix, in, PIX_BITS, signed pixel.
- fr_num, in, 4, frame id; sampled on fr_start.
- core_in_valid, out, 1, pixel valid to core.
- core_in_pix, out, PIX_BITS, pixel to core.
- core_pred_valid, in, 1, 1-cycle pulse: prediction done.
- core_pred_digit, in, 4, predicted digit.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts.
- res_num, out, 4, tagged image number.
- res_digit, out, 4, predicted digit.
- inflight, out, $clog2(MAX_INFLIGHT)+1, tag FIFO occupancy.
- acc_cnt, out, CNT_BITS, frames admitted, saturating.
- drop_cnt, out, CNT_BITS, frames dropped, saturating.
- err, out, 1, sticky protocol error.

Behaviour:
- Reset: all outputs 0. FSM in IDLE, FIFO empty, pixel counter 0.
- FSM states: IDLE, STREAM, DROP.
  - fr_start in IDLE or DROP:
    - Admit when weights_loaded=1, registered inflight<MAX_INFLIGHT, and !(res_valid & !res_ready). No same-cycle bypass from a pop.
    - On admit: push fr_num, acc_cnt++, pixel counter=0, go to STREAM.
    - Otherwise: drop_cnt++, go to DROP.
  - STREAM: each fr_v cycle forwards fr_pix to core_in_pix and asserts core_in_valid, with 1-cycle registered latency, then pixel counter++. When the counter reaches PIX_PER_FRAME-1 on a valid, go to IDLE. A fr_v on the same cycle as fr_start is counted as the frame's first pixel.
  - fr_start during STREAM: frame not admitted, drop_cnt++, err<=1. The current frame continues.
  - DROP: core_in_valid held 0. Leave only on the next fr_start, evaluated as above.
  - fr_v in IDLE: ignored.
- Completion, on core_pred_valid:
  - Pop the tag FIFO head.
  - Load res_num=head tag and res_digit=core_pred_digit; set res_valid.
  - Push and pop in the same cycle are both performed; occupancy unchanged.
  - core_pred_valid with FIFO empty: discarded, err<=1.
- Result handshake:
  - res_valid stays high until res_valid & res_ready. res_num and res_digit are stable while res_valid is high.
  - A new prediction on the accept cycle reloads directly with res_valid kept at 1.
  - A prediction while res_valid & !res_ready overwrites the result and sets err. Admission gating makes this unreachable in legal use.
- Counters saturate at all-ones.
- err clears only on reset.

Optional Feature:
- LENET_SCHED_WDOG_EN defined:
  - A cycle counter runs while inflight>0 and clears on core_pred_valid.
  - On reaching WDOG_CYCLES: flush the tag FIFO (inflight=0), set err, force FSM to IDLE.
- Undefined: no watchdog logic; WDOG_CYCLES unused.

Decomposition:
- Package lenet5_sched_pkg holds:
  - FSM state encodings (IDLE=0, STREAM=1, DROP=2).
  - Default PIX_PER_FRAME.
  - Helper function for occupancy width.
- One sub-module: lenet5_tag_fifo, a synchronous FIFO of width 4 and depth MAX_INFLIGHT.
  - Ports: push/pop/din/dout/count.
  - Simultaneous push and pop supported.
  - No internal full/empty protection; the controller guarantees legality.

Test Plan:
- Loaded, fr_num=5, 1024 pixels, then core_pred_valid with digit=7 -> 1024 core_in_valid pulses, each 1 cycle after fr_v; res_valid with res_num=5, res_digit=7; acc_cnt=1.
- weights_loaded=0 at fr_start with fr_num=3 -> no core_in_valid for that frame; drop_cnt=1; FSM in DROP until the next fr_start.
- Admit frames 1 and 2 with no prediction, then third frame 3 -> dropped; inflight=2; two preds return res_num 1 then 2, in order.
- fr_start after 500 pixels of a streaming frame -> drop_cnt++, err=1; the streaming frame still delivers 1024 pixels.
- res_ready=0 with a result pending, then fr_start -> dropped. Set res_ready=1 and pulse core_pred_valid in the same cycle as accept -> new result loaded, res_valid stays 1.
- With LENET_SCHED_WDOG_EN and WDOG_CYCLES=100: admit one frame, no prediction -> at cycle 100 inflight=0 and err=1; next frame admitted normally.
